spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 160, frame length in bits; legal range 32 or more.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per SCK half-period; legal range 2 or more.
REQ-003 SHALL have parameter RX_HEADER, default 32'h61746164, expected value of the first 32 bits received.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  system clock; all logic on rising edge
  rst  in  1  reset, synchronous and active-high
  start  in  1  request one frame; sampled in IDLE only
  tx_data  in  BUFFER_SIZE  frame to send, MSB first
  busy  out  1  frame in progress
  done  out  1  one-cycle pulse at frame end
  rx_data  out  BUFFER_SIZE  last complete received frame
  rx_valid  out  1  top 32 bits of rx_data equal RX_HEADER
  frame_count  out  16  completed frames, wraps
  err_count  out  16  frames with header mismatch, saturating
  SPI_SCK  out  1  serial clock, idles low (mode 0)
  SPI_SSEL  out  1  chip select, active low
  SPI_MOSI  out  1  serial data out
  SPI_MISO  in  1  serial data in

Function
REQ-005 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-006 IDLE: SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0, busy=0; if start=1, SHALL latch tx_data into the shift register and move to SETUP on the next edge.
REQ-007 SETUP: SPI_SSEL=0; SPI_MOSI SHALL show tx_data[BUFFER_SIZE-1]; SHALL last CLK_DIV cycles, then go to SHIFT.
REQ-008 SHIFT: per bit, SPI_SCK SHALL be low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-009 SHIFT: SPI_MISO SHALL be sampled on the clk edge where SPI_SCK goes 0->1 and shifted into the LSB of the receive register.
REQ-010 SHIFT: SPI_MOSI SHALL advance to the next bit on the edge where SPI_SCK goes 1->0.
REQ-011 After BUFFER_SIZE rising SCK edges and the final high phase, SPI_SCK SHALL return low and the block SHALL enter HOLD.
REQ-012 HOLD: SPI_SSEL=0, SPI_SCK=0, SPI_MOSI=0; SHALL last CLK_DIV cycles, then go to GAP.
REQ-013 GAP: SPI_SSEL=1; SHALL last 2*CLK_DIV cycles, then go to IDLE.
REQ-014 Total frame length from the start-accept edge to the return to IDLE SHALL be CLK_DIV*(2*BUFFER_SIZE+4) cycles.
REQ-015 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-016 On the GAP->IDLE edge, the block SHALL do all of the following in that single cycle:
  - pulse done for one cycle
  - copy the receive register to rx_data
  - set rx_valid to (rx_data[BUFFER_SIZE-1 -: 32]==RX_HEADER)
  - increment frame_count
  - increment err_count if the header mismatched, saturating at 16'hFFFF
REQ-017 rx_data, rx_valid and both counters SHALL hold their values at all other times; no partial frame is ever visible.
REQ-018 start held high continuously SHALL launch back-to-back frames, each separated by the full GAP.
REQ-019 frame_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-020 rst=1 SHALL at the next clk edge force:
  - state=IDLE
  - SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0
  - busy=0, done=0
  - rx_data=0, rx_valid=0
  - frame_count=0, err_count=0
REQ-021 rst SHALL override start in the same cycle.
REQ-022 Reset mid-frame SHALL abort the frame with no done pulse and no counter update; a start after rst falls SHALL begin a full new frame.

Verification (BUFFER_SIZE=40, CLK_DIV=2)
REQ-023 Loopback (SPI_MOSI tied to SPI_MISO), tx_data=40'h61746164A5, one start pulse -> expected response:
  - exactly 40 SCK rising edges
  - done pulses 168 cycles after the start edge
  - rx_data=40'h61746164A5, rx_valid=1
  - frame_count=1, err_count=0
REQ-024 SPI_MISO held 0 -> expected response:
  - rx_data=0, rx_valid=0
  - err_count=1
  - SPI_SSEL low for exactly 164 cycles
REQ-025 Start pulsed again 20 cycles after the first start -> ignored; exactly one done pulse.
REQ-026 Reset asserted 50 cycles into a frame -> expected response:
  - SPI_SSEL=1 and SPI_SCK=0 on the next cycle
  - no done pulse
  - counters=0
  - next frame completes normally
REQ-027 start held high for 3 frames -> expected response:
  - done pulses spaced 168 cycles apart
  - SPI_SSEL high for 4 cycles between frames
  - frame_count=3
REQ-028 err_count preloaded to 16'hFFFF via forced mismatch frames, then one more mismatch frame -> err_count stays 16'hFFFF.

Source files
------------

// File: rtl/spi_master.sv
// Mode-0 SPI master that shifts one BUFFER_SIZE-bit frame per start request.
// Publishes the received frame, its header check and frame/error counters when the frame ends.
module spi_master #(
    parameter int          BUFFER_SIZE = 160,
    parameter int          CLK_DIV     = 4,
    parameter logic [31:0] RX_HEADER   = 32'h61746164
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   rx_valid,
    output logic [15:0]            frame_count,
    output logic [15:0]            err_count,
    output logic                   SPI_SCK,
    output logic                   SPI_SSEL,
    output logic                   SPI_MOSI,
    input  logic                   SPI_MISO
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] BIT_LAST = 16'(BUFFER_SIZE - 1);

    state_t                 r_state;
    logic [15:0]            r_cnt;
    logic [15:0]            r_bit;
    logic                   r_high;
    logic [BUFFER_SIZE-1:0] r_tx;
    logic [BUFFER_SIZE-1:0] r_rx;
    logic [BUFFER_SIZE-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic [15:0]            r_frame_count;
    logic [15:0]            r_err_count;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_sck;
    logic                   r_ssel;
    logic                   r_mosi;

    logic                   w_hdr_match;

    assign w_hdr_match = (r_rx[BUFFER_SIZE-1 -: 32] == RX_HEADER);

    assign busy        = r_busy;
    assign done        = r_done;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;
    assign SPI_SCK     = r_sck;
    assign SPI_SSEL    = r_ssel;
    assign SPI_MOSI    = r_mosi;

    // Frame sequencer: state, phase timing, shift registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 16'd0;
            r_bit         <= 16'd0;
            r_high        <= 1'b0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_count <= 16'd0;
            r_err_count   <= 16'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sck         <= 1'b0;
            r_ssel        <= 1'b1;
            r_mosi        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sck <= 1'b0;
                    if (start) begin
                        r_tx    <= tx_data;
                        r_mosi  <= tx_data[BUFFER_SIZE-1];
                        r_ssel  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_state <= SETUP;
                    end else begin
                        r_mosi <= 1'b0;
                        r_ssel <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end

                SETUP: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 16'd0;
                        r_high  <= 1'b0;
                        r_state <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                // MISO is captured as SCK rises; MOSI advances as SCK falls.
                SHIFT: begin
                    if (r_cnt != DIV_LAST) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else if (!r_high) begin
                        r_cnt  <= 16'd0;
                        r_high <= 1'b1;
                        r_sck  <= 1'b1;
                        r_rx   <= {r_rx[BUFFER_SIZE-2:0], SPI_MISO};
                    end else begin
                        r_cnt  <= 16'd0;
                        r_high <= 1'b0;
                        r_sck  <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_mosi  <= 1'b0;
                            r_state <= HOLD;
                        end else begin
                            r_bit  <= r_bit + 16'd1;
                            r_tx   <= {r_tx[BUFFER_SIZE-2:0], 1'b0};
                            r_mosi <= r_tx[BUFFER_SIZE-2];
                        end
                    end
                end

                HOLD: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= 16'd0;
                        r_ssel  <= 1'b1;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                // Frame end publishes results; a held start chains straight into the next SETUP.
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt         <= 16'd0;
                        r_done        <= 1'b1;
                        r_rx_data     <= r_rx;
                        r_rx_valid    <= w_hdr_match;
                        r_frame_count <= r_frame_count + 16'd1;
                        if (!w_hdr_match && (r_err_count != 16'hFFFF)) begin
                            r_err_count <= r_err_count + 16'd1;
                        end else begin
                            r_err_count <= r_err_count;
                        end
                        if (start) begin
                            r_tx    <= tx_data;
                            r_mosi  <= tx_data[BUFFER_SIZE-1];
                            r_ssel  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= SETUP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 16'd0;
                    r_busy  <= 1'b0;
                    r_sck   <= 1'b0;
                    r_ssel  <= 1'b1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master (BUFFER_SIZE=40, CLK_DIV=2): stimulus pushes expected
// frame results, a negedge monitor pops them on every done pulse and checks SPI timing.
module tb_spi_master;

    localparam int          BS  = 40;
    localparam int          DIV = 2;
    localparam logic [31:0] HDR = 32'h61746164;
    localparam int          FRAME_CYC = DIV * (2 * BS + 4);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BS-1:0] tx_data = '0;
    logic          busy, done, rx_valid;
    logic [BS-1:0] rx_data;
    logic [15:0]   frame_count, err_count;
    logic          SPI_SCK, SPI_SSEL, SPI_MOSI, SPI_MISO;
    logic          miso_zero = 1'b0;

    assign SPI_MISO = miso_zero ? 1'b0 : SPI_MOSI;

    spi_master #(.BUFFER_SIZE(BS), .CLK_DIV(DIV), .RX_HEADER(HDR)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_count(frame_count), .err_count(err_count),
        .SPI_SCK(SPI_SCK), .SPI_SSEL(SPI_SSEL), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BS-1:0] rx;
        logic          valid;
        logic [15:0]   fc;
        logic [15:0]   ec;
        int            cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          done_cnt = 0;
    int          gap_checks = 0;
    bit          check_gap = 1'b0;
    logic [15:0] exp_fc = 16'd0;
    logic [15:0] exp_ec = 16'd0;

    int  sck_rises = 0;
    int  ssel_low  = 0;
    int  hi_run    = 0;
    bit  prev_sck  = 1'b0;
    bit  prev_ssel = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and measures SCK/SSEL activity.
    always @(negedge clk) begin
        if (rst) begin
            sck_rises = 0;
            ssel_low  = 0;
            hi_run    = 0;
            prev_sck  = 1'b0;
            prev_ssel = 1'b1;
        end else begin
            if (done) begin
                exp_t e;
                done_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rx_data", 64'(rx_data), 64'(e.rx));
                    chk("rx_valid", 64'(rx_valid), 64'(e.valid));
                    chk("frame_count", 64'(frame_count), 64'(e.fc));
                    chk("err_count", 64'(err_count), 64'(e.ec));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("sck_rises", 64'(sck_rises), 64'(BS));
                    chk("ssel_low_cycles", 64'(ssel_low), 64'(DIV * (2 * BS + 2)));
                end
                sck_rises = 0;
                ssel_low  = 0;
            end
            if (SPI_SCK && !prev_sck) sck_rises++;
            prev_sck = SPI_SCK;
            if (!SPI_SSEL) ssel_low++;
            if (SPI_SSEL) begin
                hi_run++;
            end else begin
                if (prev_ssel && check_gap) begin
                    chk("gap_ssel_high", 64'(hi_run), 64'(2 * DIV));
                    gap_checks++;
                end
                hi_run = 0;
            end
            prev_ssel = SPI_SSEL;
        end
    end

    task automatic launch(input logic [BS-1:0] tx, input bit zero, output int acc);
        @(negedge clk);
        tx_data   = tx;
        miso_zero = zero;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        acc = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic push_exp(input logic [BS-1:0] rxv, input int done_cyc);
        exp_t e;
        e.rx    = rxv;
        e.valid = (rxv[BS-1 -: 32] == HDR);
        exp_fc  = exp_fc + 16'd1;
        if (!e.valid && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
        e.fc  = exp_fc;
        e.ec  = exp_ec;
        e.cyc = done_cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic frame(input logic [BS-1:0] tx, input bit zero, input bit extra);
        int acc;
        int base;
        base = done_cnt;
        launch(tx, zero, acc);
        push_exp(zero ? '0 : tx, acc + FRAME_CYC);
        if (extra) begin
            repeat (19) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_dones(base + 1, FRAME_CYC + 50);
        repeat (20) @(negedge clk);
        chk("single_done", 64'(done_cnt), 64'(base + 1));
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int acc;
        int base;

        repeat (3) @(negedge clk);
        chk("rst_ssel", 64'(SPI_SSEL), 64'd1);
        chk("rst_sck", 64'(SPI_SCK), 64'd0);
        chk("rst_mosi", 64'(SPI_MOSI), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_counts", 64'({frame_count, err_count}), 64'd0);
        rst = 1'b0;

        frame(40'h61746164A5, 1'b0, 1'b1);
        frame(40'h61746164A5, 1'b1, 1'b0);
        frame(40'h1234567890, 1'b0, 1'b0);

        // Abort a frame 50 cycles in; no result may be published.
        base = done_cnt;
        launch(40'h61746164A5, 1'b0, acc);
        repeat (48) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ssel", 64'(SPI_SSEL), 64'd1);
        chk("abort_sck", 64'(SPI_SCK), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_counts", 64'({frame_count, err_count}), 64'd0);
        chk("abort_rx", 64'({rx_valid, rx_data}), 64'd0);
        rst = 1'b0;
        exp_fc = 16'd0;
        exp_ec = 16'd0;
        repeat (FRAME_CYC + 20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(base));

        // start held across three frames after the abort.
        base = done_cnt;
        @(negedge clk);
        tx_data   = 40'h617461643C;
        miso_zero = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        for (int k = 1; k <= 3; k++) push_exp(40'h617461643C, acc + k * FRAME_CYC);
        @(negedge clk);
        check_gap = 1'b1;
        wait_dones(base + 2, 2 * FRAME_CYC + 50);
        start = 1'b0;
        wait_dones(base + 3, FRAME_CYC + 50);
        check_gap = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_frames", 64'(frame_count), 64'd3);
        chk("b2b_gap_checks", 64'(gap_checks), 64'd2);
        chk("b2b_done_total", 64'(done_cnt), 64'(base + 3));

        // Preload counters near their limits: frame_count wraps, err_count saturates.
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        force dut.r_err_count   = 16'hFFFE;
        #1;
        release dut.r_frame_count;
        release dut.r_err_count;
        exp_fc = 16'hFFFF;
        exp_ec = 16'hFFFE;
        frame(40'h61746164A5, 1'b1, 1'b0);
        frame(40'h61746164A5, 1'b1, 1'b0);
        frame(40'hFFFFFFFF00, 1'b0, 1'b0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

endmodule
